// File: rtl/mux_cfg_pkg.sv
// Shared configuration definitions for scan-configured routing cells.
// Used by the RTL and by the scan-chain builder / bitstream generator.
package mux_cfg_pkg;

  // Widest select field the config-record helper can describe.
  localparam int MAX_SEL_W = 8;

  // Select field always starts at bit 0 of a config word.
  localparam int SEL_LSB = 0;

  // Output mode carried in the MSB of each config word.
  typedef enum logic {
    MODE_COMB = 1'b0,
    MODE_REG  = 1'b1
  } out_mode_e;

  // Config record as the bitstream generator sees one mux instance.
  typedef struct packed {
    out_mode_e              reg_mode;
    logic [MAX_SEL_W-1:0]   sel;
  } mux_cfg_t;

  // Config bits held by one mux instance with n_in data inputs.
  function automatic int cfg_width(input int n_in);
    return $clog2(n_in) + 1;
  endfunction

  // Bit position of reg_mode inside a config word; it sits just above sel.
  function automatic int mode_bit_index(input int n_in);
    return cfg_width(n_in) - 1;
  endfunction

  // Packs a config record into a right-aligned config word. Bit
  // [cfg_width(n_in)-1] is shifted into the chain first, bit 0 last.
  function automatic logic [MAX_SEL_W:0] cfg_pack(input mux_cfg_t c, input int n_in);
    logic [MAX_SEL_W:0] word;
    word = '0;
    for (int i = 0; i < MAX_SEL_W; i++) begin
      if (i < cfg_width(n_in) - 1) begin
        word[SEL_LSB + i] = c.sel[i];
      end
    end
    word[mode_bit_index(n_in)] = c.reg_mode;
    return word;
  endfunction

endpackage

// File: rtl/scan_cfg_seg.sv
// One segment of the config scan chain: a shadow shift register that absorbs
// serial bits, and an active register that only changes on commit, so routing
// driven from the active copy never sees half-shifted values.
module scan_cfg_seg #(
  parameter int CFG_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             scan_en,
  input  logic             scan_in,
  input  logic             scan_commit,
  output logic             scan_out,
  output logic [CFG_W-1:0] cfg
);

  logic [CFG_W-1:0] shadow_reg;
  logic [CFG_W-1:0] shadow_next;
  logic [CFG_W-1:0] active_reg;

  // Next shadow value: shift one position toward the MSB, new bit at the LSB.
  always_comb begin
    shadow_next = {shadow_reg[CFG_W-2:0], scan_in};
  end

  // Shadow shifts on scan_en; active copies the pre-edge shadow on commit.
  // Both can happen on the same edge, in which case commit sees the old shadow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_reg <= '0;
      active_reg <= '0;
    end else begin
      if (scan_en) begin
        shadow_reg <= shadow_next;
      end
      if (scan_commit) begin
        active_reg <= shadow_reg;
      end
    end
  end

  // Chain output comes straight from a flop so there is no combinational
  // path from scan_in to the next instance.
  assign scan_out = shadow_reg[CFG_W-1];
  assign cfg      = active_reg;

endmodule

// File: rtl/scan_mux_n.sv
// N-input, WIDTH-bit routing mux for the fabric interconnect. Select and output
// mode come from a local scan-chain segment; the output is either the raw mux
// value or a registered copy of it.
module scan_mux_n
  import mux_cfg_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  scan_en,
  input  logic                  scan_in,
  input  logic                  scan_commit,
  output logic                  scan_out,
  input  logic [N_IN*WIDTH-1:0] data_in,
  output logic [WIDTH-1:0]      data_out
);

  localparam int SEL_W        = $clog2(N_IN);
  localparam int CFG_W        = cfg_width(N_IN);
  localparam int REG_MODE_BIT = mode_bit_index(N_IN);
  localparam int N_SLOT       = 1 << SEL_W;

  logic [CFG_W-1:0] cfg;
  logic [SEL_W-1:0] sel;
  out_mode_e        mode;
  logic [WIDTH-1:0] lane [N_SLOT];
  logic [WIDTH-1:0] mux_val;
  logic [WIDTH-1:0] out_q_reg;

  scan_cfg_seg #(
    .CFG_W (CFG_W)
  ) u_seg (
    .clk         (clk),
    .reset       (reset),
    .scan_en     (scan_en),
    .scan_in     (scan_in),
    .scan_commit (scan_commit),
    .scan_out    (scan_out),
    .cfg         (cfg)
  );

  assign sel  = cfg[SEL_LSB +: SEL_W];
  assign mode = out_mode_e'(cfg[REG_MODE_BIT]);

  // Lane table padded to a power of two: every select code has a slot, and the
  // slots beyond N_IN-1 are tied to zero. This is the out-of-range check, and
  // it also keeps the output from ever floating.
  for (genvar gi = 0; gi < N_SLOT; gi++) begin : g_lane
    if (gi < N_IN) begin : g_real
      assign lane[gi] = data_in[gi*WIDTH +: WIDTH];
    end else begin : g_pad
      assign lane[gi] = '0;
    end
  end

  // Indexed mux over the padded lane table.
  always_comb begin
    mux_val = lane[sel];
  end

  // Registered copy tracks the mux every cycle in both modes, so switching
  // into registered mode immediately presents a valid value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q_reg <= '0;
    end else begin
      out_q_reg <= mux_val;
    end
  end

  // Output mode select: combinational pass-through or one-cycle registered.
  always_comb begin
    data_out = mux_val;
    if (mode == MODE_REG) begin
      data_out = out_q_reg;
    end
  end

endmodule

// File: tb/tb_scan_mux_n.sv
// Directed bench for scan_mux_n: one 4x8 instance and one 3x4 instance sharing
// clock, reset and scan controls. Expected values are queued when stimulus is
// applied and popped when the output is sampled.
module tb_scan_mux_n;

  logic        clk;
  logic        reset;
  logic        scan_en;
  logic        scan_in;
  logic        scan_commit;
  logic        scan_out_a;
  logic        scan_out_b;
  logic [31:0] data_a;
  logic [7:0]  dout_a;
  logic [11:0] data_b;
  logic [3:0]  dout_b;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q [$];
  string      tag_q [$];

  scan_mux_n #(.N_IN(4), .WIDTH(8)) dut_a (
    .clk         (clk),
    .reset       (reset),
    .scan_en     (scan_en),
    .scan_in     (scan_in),
    .scan_commit (scan_commit),
    .scan_out    (scan_out_a),
    .data_in     (data_a),
    .data_out    (dout_a)
  );

  scan_mux_n #(.N_IN(3), .WIDTH(4)) dut_b (
    .clk         (clk),
    .reset       (reset),
    .scan_en     (scan_en),
    .scan_in     (scan_in),
    .scan_commit (scan_commit),
    .scan_out    (scan_out_b),
    .data_in     (data_b),
    .data_out    (dout_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard bound on total run time.
  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic expect_val(input string tag, input logic [7:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic chk(input logic [7:0] obs);
    logic [7:0] e;
    string      t;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty: observed=%h required=queued_entry", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s: observed=%h required=%h", t, obs, e);
      end
      $display("check %s observed=%h expected=%h", t, obs, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift(input logic b);
    scan_en = 1'b1;
    scan_in = b;
    tick();
    scan_en = 1'b0;
    scan_in = 1'b0;
  endtask

  task automatic commit();
    scan_commit = 1'b1;
    tick();
    scan_commit = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    scan_en     = 1'b0;
    scan_in     = 1'b0;
    scan_commit = 1'b0;
    data_a      = {8'h44, 8'h33, 8'h22, 8'h11};
    data_b      = 12'h321;

    // 1: reset state, visible before any clock edge
    #2;
    expect_val("t1_scan_out", 8'h00); chk({7'd0, scan_out_a});
    expect_val("t1_dout", 8'h11);     chk(dout_a);
    // scan activity under reset changes nothing
    scan_en = 1'b1; scan_in = 1'b1; scan_commit = 1'b1;
    repeat (3) tick();
    expect_val("t1_hold_scan_out", 8'h00); chk({7'd0, scan_out_a});
    expect_val("t1_hold_shadow", 8'h00);   chk({5'd0, dut_a.u_seg.shadow_reg});
    expect_val("t1_hold_dout", 8'h11);     chk(dout_a);
    scan_en = 1'b0; scan_in = 1'b0; scan_commit = 1'b0;
    reset = 1'b0;
    tick();

    // 2: combinational mode, sel=2
    shift(1'b0); shift(1'b1); shift(1'b0);
    data_a[23:16] = 8'hA5;
    commit();
    expect_val("t2_comb_a5", 8'hA5); chk(dout_a);
    data_a[23:16] = 8'h5A;
    #1;
    expect_val("t2_comb_5a", 8'h5A); chk(dout_a);

    // 3: registered mode, sel=1
    shift(1'b1); shift(1'b0); shift(1'b1);
    commit();
    data_a[15:8] = 8'h3C;
    #1;
    expect_val("t3_before_edge", 8'h5A); chk(dout_a);
    tick();
    expect_val("t3_after_edge", 8'h3C); chk(dout_a);
    data_a[15:8] = 8'h77;
    #1;
    expect_val("t3_held", 8'h3C); chk(dout_a);
    tick();
    expect_val("t3_next", 8'h77); chk(dout_a);

    // 5: six shifts without commit; scan_out replays bits 1,0,1,1
    shift(1'b1); expect_val("t5_dout_s1", 8'h77); chk(dout_a);
    shift(1'b0); expect_val("t5_dout_s2", 8'h77); chk(dout_a);
    shift(1'b1); expect_val("t5_so_c4", 8'h01);   chk({7'd0, scan_out_a});
    shift(1'b1); expect_val("t5_so_c5", 8'h00);   chk({7'd0, scan_out_a});
    expect_val("t5_dout_s4", 8'h77); chk(dout_a);
    shift(1'b1); expect_val("t5_so_c6", 8'h01);   chk({7'd0, scan_out_a});
    shift(1'b0); expect_val("t5_so_s6", 8'h01);   chk({7'd0, scan_out_a});
    expect_val("t5_dout_s6", 8'h77); chk(dout_a);
    // same-cycle shift+commit: active takes 110 (reg, sel=2), shadow becomes 100
    scan_en = 1'b1; scan_in = 1'b0; scan_commit = 1'b1;
    tick();
    scan_en = 1'b0; scan_commit = 1'b0;
    expect_val("t5_sc_active", 8'h06); chk({5'd0, dut_a.u_seg.active_reg});
    expect_val("t5_sc_dout_q", 8'h77); chk(dout_a);
    expect_val("t5_sc_so", 8'h01);     chk({7'd0, scan_out_a});
    tick();
    expect_val("t5_sc_sel2", 8'h5A); chk(dout_a);
    commit();
    tick();
    expect_val("t5_post_shift_sel0", 8'h11); chk(dout_a);

    // 4: out-of-range select on the 3-input instance
    shift(1'b0); shift(1'b1); shift(1'b1);
    expect_val("t4_so_b", 8'h00); chk({7'd0, scan_out_b});
    commit();
    expect_val("t4_a_sel3", 8'h44); chk(dout_a);
    data_b = 12'hFFF; #1;
    expect_val("t4_b_fff", 8'h00); chk({4'd0, dout_b});
    data_b = 12'hA5C; #1;
    expect_val("t4_b_a5c", 8'h00); chk({4'd0, dout_b});
    tick();
    data_b = 12'h123; #1;
    expect_val("t4_b_123", 8'h00); chk({4'd0, dout_b});

    // 6: reset pulsed between edges after 2 of 3 shifts
    shift(1'b1); shift(1'b1);
    expect_val("t6_pre_so", 8'h01); chk({7'd0, scan_out_a});
    #2;
    reset = 1'b1;
    #1;
    expect_val("t6_shadow", 8'h00); chk({5'd0, dut_a.u_seg.shadow_reg});
    expect_val("t6_active", 8'h00); chk({5'd0, dut_a.u_seg.active_reg});
    expect_val("t6_out_q", 8'h00);  chk(dut_a.out_q_reg);
    expect_val("t6_so", 8'h00);     chk({7'd0, scan_out_a});
    expect_val("t6_dout", 8'h11);   chk(dout_a);
    reset = 1'b0;
    tick();
    commit();
    expect_val("t6_no_partial", 8'h11); chk(dout_a);
    shift(1'b1);
    commit();
    expect_val("t6_fresh_sel1", 8'h77); chk(dout_a);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
